// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I encodings for the multicycle controller and datapath
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'h03,
        OP_ITYPE  = 7'h13,
        OP_STORE  = 7'h23,
        OP_RTYPE  = 7'h33,
        OP_BRANCH = 7'h63,
        OP_JAL    = 7'h6f
    } opcodetype;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_control_t;

    typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_t;
    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10, SRCA_ZERO = 2'b11} alu_src_a_t;
    typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10, SRCB_ZERO = 2'b11} alu_src_b_t;
    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10, RES_ZERO = 2'b11} result_src_t;

    function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr, input logic [1:0] src);
        case (src)
            IMM_I:   imm_extend = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_extend = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_extend = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm_extend = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// rtl/multicycle_datapath_if.sv - controller/memory <-> datapath signal bundle; Misalign exists only with DP_MISALIGN_CHK_EN
interface multicycle_datapath_if;
    import riscv_pkg::*;

    logic [1:0]      ImmSrc;
    logic [1:0]      ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ResultSrc;
    logic            AdrSrc;
    logic [2:0]      ALUControl;
    logic            IRWrite;
    logic            PCWrite;
    logic            RegWrite;
    logic [XLEN-1:0] ReadData;
    logic [XLEN-1:0] Adr;
    logic [XLEN-1:0] WriteData;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            Zero;
`ifdef DP_MISALIGN_CHK_EN
    logic            Misalign;
`endif

    modport master (
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
        output IRWrite, PCWrite, RegWrite, ReadData,
`ifdef DP_MISALIGN_CHK_EN
        input  Misalign,
`endif
        input  Adr, WriteData, op, funct3, funct7b5, Zero
    );

    modport slave (
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
        input  IRWrite, PCWrite, RegWrite, ReadData,
`ifdef DP_MISALIGN_CHK_EN
        output Misalign,
`endif
        output Adr, WriteData, op, funct3, funct7b5, Zero
    );

endinterface

// File: rtl/riscv_regfile.sv
// rtl/riscv_regfile.sv - 32x32 register file, two combinational reads, one synchronous write, x0 hardwired to 0
module riscv_regfile
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      a1,
    input  logic [4:0]      a2,
    input  logic [4:0]      a3,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (a3 != 5'd0)) begin
            regs[a3] <= wd;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is visible one cycle later.
    assign rd1 = (a1 == 5'd0) ? '0 : regs[a1];
    assign rd2 = (a2 == 5'd0) ? '0 : regs[a2];

endmodule

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multicycle RV32I datapath; optional Misalign flag under DP_MISALIGN_CHK_EN
module multicycle_datapath
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_datapath_if.slave   bus
);

    logic [XLEN-1:0] pc, old_pc, ir, a_reg, b_reg, alu_out, data_reg;
    logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;

    riscv_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (bus.RegWrite),
        .a1    (ir[19:15]),
        .a2    (ir[24:20]),
        .a3    (ir[11:7]),
        .wd    (result),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    assign imm_ext = imm_extend(ir, bus.ImmSrc);

    always_comb begin
        case (bus.ALUSrcA)
            SRCA_PC:    src_a = pc;
            SRCA_OLDPC: src_a = old_pc;
            SRCA_A:     src_a = a_reg;
            default:    src_a = '0;
        endcase
        case (bus.ALUSrcB)
            SRCB_B:     src_b = b_reg;
            SRCB_IMM:   src_b = imm_ext;
            SRCB_FOUR:  src_b = 32'd4;
            default:    src_b = '0;
        endcase
    end

    always_comb begin
        case (bus.ALUControl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        case (bus.ResultSrc)
            RES_ALUOUT:    result = alu_out;
            RES_DATA:      result = data_reg;
            RES_ALURESULT: result = alu_result;
            default:       result = '0;
        endcase
    end

    // OldPC samples the pre-update PC when fetch writes IR and PC on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            old_pc   <= '0;
            ir       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_out  <= '0;
            data_reg <= '0;
        end else begin
            a_reg    <= rd1;
            b_reg    <= rd2;
            alu_out  <= alu_result;
            data_reg <= bus.ReadData;
            if (bus.IRWrite) begin
                ir     <= bus.ReadData;
                old_pc <= pc;
            end
            if (bus.PCWrite) pc <= result;
        end
    end

    assign bus.Adr       = bus.AdrSrc ? result : pc;
    assign bus.WriteData = b_reg;
    assign bus.op        = ir[6:0];
    assign bus.funct3    = ir[14:12];
    assign bus.funct7b5  = ir[30];
    assign bus.Zero      = (alu_result == '0);

`ifdef DP_MISALIGN_CHK_EN
    assign bus.Misalign = (bus.PCWrite && (result[1:0] != 2'b00)) ||
                          (bus.AdrSrc && (bus.Adr[1:0] != 2'b00));
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed bench for multicycle_datapath; Misalign checks under DP_MISALIGN_CHK_EN
module tb_multicycle_datapath;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_datapath_if bus();

    multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } alu_vec_t;

    alu_vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ImmSrc     = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.AdrSrc     = 1'b0;
        bus.ALUControl = 3'b000;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
    endtask

    task automatic load_ir(input logic [31:0] instr);
        idle();
        bus.ReadData = instr;
        bus.IRWrite  = 1'b1;
        tick();
        bus.IRWrite  = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] n, input logic [31:0] v);
        load_ir({12'h000, 5'd0, 3'd0, n, 7'h13});
        bus.ReadData = v;
        tick();
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        tick();
        idle();
    endtask

    // Route x[n] through A and the ALU (A + 0) onto Adr.
    task automatic read_reg(input logic [4:0] n, output logic [31:0] v);
        load_ir({12'h000, n, 3'd0, 5'd0, 7'h13});
        tick();
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b11;
        bus.ALUControl = 3'b000;
        bus.ResultSrc  = 2'b10;
        bus.AdrSrc     = 1'b1;
        #1;
        v = bus.Adr;
        idle();
    endtask

    task automatic observe_oldpc(output logic [31:0] v);
        bus.ALUSrcA    = 2'b01;
        bus.ALUSrcB    = 2'b11;
        bus.ALUControl = 3'b000;
        bus.ResultSrc  = 2'b10;
        bus.AdrSrc     = 1'b1;
        #1;
        v = bus.Adr;
        idle();
    endtask

    task automatic fetch(input logic [31:0] instr);
        idle();
        bus.ReadData  = instr;
        bus.IRWrite   = 1'b1;
        bus.PCWrite   = 1'b1;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        tick();
        idle();
        #1;
    endtask

    logic [31:0] v;

    initial begin
        vecs[0] = '{3'b000, 32'd5,        32'd7,        32'd12,       1'b0};
        vecs[1] = '{3'b001, 32'd9,        32'd9,        32'd0,        1'b1};
        vecs[2] = '{3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[3] = '{3'b010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        vecs[4] = '{3'b011, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0};
        vecs[5] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vecs[6] = '{3'b101, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[7] = '{3'b001, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
        vecs[8] = '{3'b111, 32'd5,        32'd7,        32'd0,        1'b1};
        vecs[9] = '{3'b100, 32'd5,        32'd7,        32'd0,        1'b1};

        idle();
        bus.ReadData = 32'h0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_adr", bus.Adr, 32'h0);
        chk("reset_op", {25'd0, bus.op}, 32'h0);
        chk("reset_funct3", {29'd0, bus.funct3}, 32'h0);
        chk("reset_funct7b5", {31'd0, bus.funct7b5}, 32'h0);
        chk("reset_writedata", bus.WriteData, 32'h0);

        // addi x1,x0,5
        fetch(32'h00500093);
        chk("fetch1_op", {25'd0, bus.op}, 32'h13);
        chk("fetch1_pc", bus.Adr, 32'h4);
        observe_oldpc(v);
        chk("fetch1_oldpc", v, 32'h0);
        tick();
        bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; bus.ImmSrc = 2'b00;
        #1;
        chk("addi_zero", {31'd0, bus.Zero}, 32'h0);
        tick();
        idle(); bus.ResultSrc = 2'b00; bus.RegWrite = 1'b1;
        tick();
        idle();
        #1;
        chk("fetch2_adr", bus.Adr, 32'h4);

        // add x2,x1,x1
        fetch(32'h00108133);
        chk("fetch2_op", {25'd0, bus.op}, 32'h33);
        chk("fetch2_pc", bus.Adr, 32'h8);
        observe_oldpc(v);
        chk("fetch2_oldpc", v, 32'h4);
        tick();
        bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b00; bus.ALUControl = 3'b000;
        #1;
        chk("add_zero", {31'd0, bus.Zero}, 32'h0);
        tick();
        idle(); bus.ResultSrc = 2'b00; bus.RegWrite = 1'b1;
        tick();
        idle();
        read_reg(5'd1, v); chk("x1_val", v, 32'd5);
        read_reg(5'd2, v); chk("x2_val", v, 32'd10);

        // sw x2,8(x0)
        load_ir(32'h00202423);
        chk("sw_op", {25'd0, bus.op}, 32'h23);
        chk("sw_funct3", {29'd0, bus.funct3}, 32'h2);
        tick();
        chk("sw_writedata", bus.WriteData, 32'd10);
        bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b01; bus.ImmSrc = 2'b01;
        tick();
        idle(); bus.ResultSrc = 2'b00; bus.AdrSrc = 1'b1;
        #1;
        chk("sw_adr", bus.Adr, 32'h8);
        idle();

        load_ir(32'h40000033);
        chk("sub_funct7b5", {31'd0, bus.funct7b5}, 32'h1);

        // beq x0,x0,-8 fetched from 0x10
        bus.ReadData = 32'h10;
        tick();
        bus.ResultSrc = 2'b01; bus.PCWrite = 1'b1;
        tick();
        idle();
        #1;
        chk("beq_pc_setup", bus.Adr, 32'h10);
        fetch(32'hFE000CE3);
        observe_oldpc(v);
        chk("beq_oldpc", v, 32'h10);
        bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b01; bus.ImmSrc = 2'b10;
        bus.ResultSrc = 2'b10; bus.AdrSrc = 1'b1;
        #1;
        chk("beq_target", bus.Adr, 32'h8);
        tick();
        idle();
        bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b00; bus.ALUControl = 3'b001;
        bus.ResultSrc = 2'b00; bus.AdrSrc = 1'b1;
        #1;
        chk("beq_zero", {31'd0, bus.Zero}, 32'h1);
        chk("beq_aluout", bus.Adr, 32'h8);
        bus.AdrSrc = 1'b0; bus.PCWrite = 1'b1;
        tick();
        idle();
        #1;
        chk("beq_pc", bus.Adr, 32'h8);

        write_reg(5'd0, 32'h1234);
        read_reg(5'd0, v); chk("x0_read", v, 32'h0);
        read_reg(5'd2, v); chk("x2_kept", v, 32'd10);

        for (int i = 0; i < 10; i++) begin
            write_reg(5'd3, vecs[i].a);
            write_reg(5'd4, vecs[i].b);
            load_ir(32'h004182B3);
            tick();
            bus.ALUSrcA = 2'b10; bus.ALUSrcB = 2'b00; bus.ALUControl = vecs[i].ctl;
            bus.ResultSrc = 2'b10; bus.AdrSrc = 1'b1;
            #1;
            chk($sformatf("alu%0d_res", i), bus.Adr, vecs[i].res);
            chk($sformatf("alu%0d_zero", i), {31'd0, bus.Zero}, {31'd0, vecs[i].zero});
            idle();
        end

`ifdef DP_MISALIGN_CHK_EN
        bus.ReadData = 32'h6;
        tick();
        bus.ResultSrc = 2'b01; bus.PCWrite = 1'b1;
        #1;
        chk("misalign_pc6", {31'd0, bus.Misalign}, 32'h1);
        bus.PCWrite = 1'b0;
        #1;
        chk("misalign_clear", {31'd0, bus.Misalign}, 32'h0);
        idle();
`endif

        // Reset lands while a writeback to x6 is pending.
        load_ir({12'h000, 5'd0, 3'd0, 5'd6, 7'h13});
        bus.ReadData = 32'h55;
        tick();
        bus.ResultSrc = 2'b01; bus.RegWrite = 1'b1;
        #2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("midreset_pc", bus.Adr, 32'h0);
        read_reg(5'd6, v); chk("midreset_x6", v, 32'h0);
        read_reg(5'd2, v); chk("midreset_x2", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
